// File: rtl/prog_loader.sv
// Writable 16-bit program store loaded from a byte stream; stalls the core until loaded.
// Optional checksum byte at the end of each load is enabled with LOADER_CHECKSUM_EN.
//   state   | meaning
//   IDLE    | no program, core stalled
//   RECV_LO | waiting for low byte of instruction wptr
//   RECV_HI | waiting for high byte, writes mem[wptr]
//   CHECK   | waiting for checksum byte (LOADER_CHECKSUM_EN only)
//   RUN     | program loaded, core enabled
module prog_loader #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               core_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECV_LO = 3'd1,
    S_RECV_HI = 3'd2,
    S_RUN     = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [7:0]         lo_q, lo_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic               hs;
  logic               mem_we;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
`endif

  assign hs = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    lo_d    = lo_q;
    mem_we  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    // start has priority over any byte presented in the same cycle
    if (start) begin
      state_d = S_RECV_LO;
      wptr_d  = '0;
      lo_d    = '0;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_RECV_LO: if (hs) begin
          lo_d    = in_data;
          state_d = S_RECV_HI;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
        end
        S_RECV_HI: if (hs) begin
          mem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (wptr_q == ADDR_W'(DEPTH - 1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_RUN;
`endif
          end else begin
            wptr_d  = wptr_q + 1'b1;
            state_d = S_RECV_LO;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: if (hs) begin
          if (8'(sum_q + in_data) == 8'd0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      lo_q    <= lo_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wptr_q] <= {in_data, lo_q};
    end
  end

  assign in_ready    = (state_q == S_RECV_LO) || (state_q == S_RECV_HI) || (state_q == S_CHECK);
  assign busy        = in_ready;
  assign core_en     = (state_q == S_RUN);
  assign done        = (state_q == S_RUN);
  assign fetch_instr = (state_q == S_RUN) ? mem_q[fetch_addr] : '0;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory images are queued as bytes are driven
// and popped while probing fetch_instr in RUN.
module tb_prog_loader;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [2:0]  fetch_addr = 3'd0;
  logic        in_ready, core_en, busy, done, err;
  logic [15:0] fetch_instr;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  stream[2*DEPTH];

  prog_loader dut (
    .clock(clock), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .core_en(core_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // presents a byte and returns after its handshake edge; in_valid stays high
  task automatic send_byte(input logic [7:0] b, output int waits);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check_val("hs_timeout", 0, 1);
    else tick();
    waits = n;
  endtask

  task automatic push_image;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({stream[2*i+1], stream[2*i]});
  endtask

  task automatic verify_image(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = 3'(a);
      #1;
      if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, 0, 1);
      else check_val(tag, fetch_instr, exp_q.pop_front());
    end
  endtask

  // sends the stream (plus checksum byte when enabled); gap idle cycles between bytes
  task automatic send_stream(input string tag, input int gap);
    int w;
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 2*DEPTH; i++) begin
      sum = sum + stream[i];
`ifndef LOADER_CHECKSUM_EN
      if (i == 2*DEPTH-1) check_val({tag, "_core_en_before_last"}, core_en, 0);
`endif
      send_byte(stream[i], w);
      check_val({tag, "_rdy"}, w, 0);
      if (gap > 0 && i != 2*DEPTH-1) begin
        in_valid = 1'b0;
        repeat (gap) begin
          check_val({tag, "_busy_gap"}, busy, 1);
          tick();
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    check_val({tag, "_core_en_before_last"}, core_en, 0);
    send_byte(8'(-sum), w);
    check_val({tag, "_ck_rdy"}, w, 0);
`endif
    in_valid = 1'b0;
  endtask

  task automatic check_running(input string tag);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_core_en"}, core_en, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_err"}, err, 0);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clock);
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = 3'(a);
      #1;
      check_val("rst_fetch", fetch_instr, 16'h0000);
    end
    check_val("rst_core_en", core_en, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_done", done, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err", err, 0);
    #2 rst_n = 1'b1;
    tick();
    check_val("idle_in_ready", in_ready, 0);

    // full load, valid held high
    for (int k = 0; k < DEPTH; k++) begin
      stream[2*k]   = 8'(k + 1);
      stream[2*k+1] = 8'((k + 1) << 4);
    end
    pulse_start();
    check_val("full_busy", busy, 1);
    check_val("full_ready", in_ready, 1);
    push_image();
    send_stream("full", 0);
    check_running("full");
    verify_image("full_img");

    // restart mid-load: the byte presented with start is dropped
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), w);
    in_valid = 1'b0;
    fetch_addr = 3'd0;
    #1;
    check_val("load_fetch_nop", fetch_instr, 16'h0000);
    in_valid = 1'b1;
    in_data  = 8'h77;
    start    = 1'b1;
    check_val("restart_ready", in_ready, 1);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check_val("restart_busy", busy, 1);
    check_val("restart_done", done, 0);
    for (int i = 0; i < 2*DEPTH; i++) stream[i] = (i % 2 == 0) ? 8'hAA : 8'h55;
    push_image();
    send_stream("restart", 0);
    check_running("restart");
    verify_image("restart_img");

    // bytes offered in RUN are ignored
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (10) begin
      check_val("run_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check_running("run_ign");
    push_image();
    verify_image("run_img");

    // backpressure gaps reproduce the full-load image
    for (int k = 0; k < DEPTH; k++) begin
      stream[2*k]   = 8'(k + 1);
      stream[2*k+1] = 8'((k + 1) << 4);
    end
    pulse_start();
    push_image();
    send_stream("gap", 3);
    check_running("gap");
    verify_image("gap_img");

    // reset mid-load
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'h5A, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_in_ready", in_ready, 0);
    check_val("midrst_core_en", core_en, 0);
    #1 rst_n = 1'b1;
    tick();
    check_val("midrst_fetch", fetch_instr, 16'h0000);

`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 2*DEPTH; i++) stream[i] = 8'h01;
    pulse_start();
    push_image();
    for (int i = 0; i < 2*DEPTH; i++) send_byte(stream[i], w);
    check_val("ck_check_ready", in_ready, 1);
    check_val("ck_check_done", done, 0);
    send_byte(8'hF0, w);
    in_valid = 1'b0;
    check_running("ck_pass");
    verify_image("ck_img");

    pulse_start();
    for (int i = 0; i < 2*DEPTH; i++) send_byte(stream[i], w);
    send_byte(8'hF1, w);
    in_valid = 1'b0;
    check_val("ck_fail_err", err, 1);
    check_val("ck_fail_core_en", core_en, 0);
    check_val("ck_fail_done", done, 0);
    check_val("ck_fail_busy", busy, 0);
    check_val("ck_fail_in_ready", in_ready, 0);
    fetch_addr = 3'd2;
    #1;
    check_val("ck_fail_fetch", fetch_instr, 16'h0000);
    tick();
    check_val("ck_err_sticky", err, 1);
    pulse_start();
    check_val("ck_err_clear", err, 0);
    check_val("ck_restart_busy", busy, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writable program store that replaces the fixed instruction ROM.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instructions into an 8-entry program memory.
- Holds the core stalled during loading and releases it once the full program is written.
- Sits between the external/host byte source and the core fetch path (PC -> instruction).

Parameters:
- DEPTH, 8, number of instruction entries; must be a power of two, at least 2.
- INSTR_W, 16, instruction width; fixed at 2 bytes, other values unsupported.
- ADDR_W, $clog2(DEPTH), fetch/write address width (3 for the default).

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new load.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  program byte; low byte of each instruction first.
- in_ready  output  1  loader accepts a byte this cycle.
- fetch_addr  input  ADDR_W  core PC.
- fetch_instr  output  INSTR_W  instruction at fetch_addr; combinational read.
- core_en  output  1  enables the core's PC and register clocking.
- busy  output  1  load in progress.
- done  output  1  program loaded, core running.
- err  output  1  load failed; sticky until the next start.

Behaviour:
- Asynchronous reset:
  - state IDLE; in_ready=0, core_en=0, busy=0, done=0, err=0.
  - Write pointer wptr=0, low-byte holding register=0.
  - All memory entries = 16'h0000 (NOP: opcode 0, no register write).
- States: IDLE, RECV_LO, RECV_HI, RUN; CHECK exists only with the optional feature.
- IDLE: in_ready=0, core_en=0. start -> RECV_LO with wptr=0, busy=1.
- RECV_LO: in_ready=1.
  - Handshake (in_valid & in_ready) latches in_data into the low register and moves to RECV_HI.
- RECV_HI: in_ready=1.
  - Handshake writes mem[wptr] = {in_data, low} on the same edge.
  - If wptr==DEPTH-1: go to RUN (or CHECK if enabled). Otherwise wptr+1 and go to RECV_LO.
- RUN: core_en=1, done=1, busy=0, in_ready=0.
  - State holds until start or reset.
- Outputs are registered from state, valid the cycle after entry.
  - Latency from the last byte handshake to core_en=1 is 1 cycle.
- fetch_instr = mem[fetch_addr] only in RUN; forced to 16'h0000 in every other state, so a stalled core sees NOPs.
- start in any state, including RUN and mid-load:
  - Restarts the load: wptr=0, partial low byte discarded, core_en=0, done=0, err=0, state RECV_LO.
  - Previously written entries are kept until overwritten.
- start and a byte handshake in the same cycle: start wins and the byte is dropped. in_ready is still 1 in that cycle, so the source must treat the byte as consumed.
- in_valid is ignored in IDLE and RUN; no memory write occurs.
- in_valid may be deasserted between bytes for any number of cycles; state and wptr hold.
- wptr never wraps: exactly 2*DEPTH bytes are accepted per load.
- Reset mid-load returns to IDLE with memory cleared to NOP.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled: after the last instruction the FSM enters CHECK (in_ready=1) and accepts one extra checksum byte.
  - Pass condition: the 8-bit sum modulo 256 of all 2*DEPTH program bytes plus the checksum byte equals 0.
  - Pass -> RUN.
  - Fail -> IDLE with err=1, core_en=0, done=0; fetch_instr stays 0x0000.
  - Running sum is cleared on start.
- Disabled: no CHECK state, no checksum byte; err is tied to 0.

Test Plan:
- Reset, then probe fetch_addr 0..7 -> fetch_instr=0x0000; core_en=0, in_ready=0, done=0.
- Full load:
  - Stimulus: start, then 16 bytes 0x01,0x10,0x02,0x20,...,0x08,0x80 with in_valid held high.
  - Required: in_ready high for 16 cycles, then done=1 and core_en=1 one cycle after the last byte; fetch_addr=3 -> 0x4004, fetch_addr=7 -> 0x8008.
- Backpressure gaps: insert 3 idle cycles of in_valid=0 between every byte -> same memory image as the full load; busy=1 throughout.
- Restart mid-load: after 5 bytes, pulse start together with in_valid -> that byte is dropped; a fresh 16-byte load of 0xAA,0x55 repeated -> every entry reads 0x55AA.
- In RUN, drive in_valid=1 with in_data=0xFF for 10 cycles -> in_ready=0 and memory unchanged.
- Checksum (LOADER_CHECKSUM_EN):
  - 16 bytes of 0x01 followed by 0xF0 -> RUN.
  - The same stream followed by 0xF1 -> err=1, core_en=0, state IDLE.
  - A following start -> err clears.
